ttt_turn_controller: RTL and testbench

Sequences a tic-tac-toe game by arbitrating a single 9-cell board register between the human player (debounced move/select pulses) and the computer move generator. Owns board state, cursor, turn order and win/draw detection. Feeds the board and cursor to the video controller, and drives the request/accept handshake of the computer opponent.

---
 rtl/ttt_pkg.sv | 61 ++++++
 rtl/ttt_win_check.sv | 28 ++
 rtl/ttt_turn_controller.sv | 171 +++++++++++++++++
 tb/tb_ttt_turn_controller.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types, constants and board helpers for the tic-tac-toe turn controller
// and the computer opponent.
package ttt_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        PLAYER = 2'b01,
        CPU    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        P_WIN = 2'b01,
        C_WIN = 2'b10,
        DRAW  = 2'b11
    } winner_t;

    typedef enum logic [2:0] {
        P_TURN,
        C_REQ,
        C_WAIT,
        CHECK,
        DONE
    } state_t;

    // Three cell indices per line: rows, columns, then the two diagonals.
    localparam logic [NUM_LINES-1:0][2:0][3:0] WIN_LINES = {
        {4'd6, 4'd4, 4'd2},
        {4'd8, 4'd4, 4'd0},
        {4'd8, 4'd5, 4'd2},
        {4'd7, 4'd4, 4'd1},
        {4'd6, 4'd3, 4'd0},
        {4'd8, 4'd7, 4'd6},
        {4'd5, 4'd4, 4'd3},
        {4'd2, 4'd1, 4'd0}
    };

    // Indices above 8 read as EMPTY; callers must range-check separately.
    function automatic logic [1:0] cell_at(input logic [2*NUM_CELLS-1:0] b,
                                           input logic [3:0]             idx);
        logic [1:0] c;
        c = EMPTY;
        for (int i = 0; i < NUM_CELLS; i++)
            if (idx == 4'(i)) c = b[2*i +: 2];
        return c;
    endfunction

    function automatic logic [2*NUM_CELLS-1:0] cell_put(input logic [2*NUM_CELLS-1:0] b,
                                                        input logic [3:0]             idx,
                                                        input logic [1:0]             v);
        logic [2*NUM_CELLS-1:0] r;
        r = b;
        for (int i = 0; i < NUM_CELLS; i++)
            if (idx == 4'(i)) r[2*i +: 2] = v;
        return r;
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line/full detector for one mark; shared with the computer opponent.
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [2*NUM_CELLS-1:0] board,
    input  logic [1:0]             mark,
    output logic                   win,
    output logic                   full
);

    logic [NUM_LINES-1:0] w_hit;
    logic [NUM_CELLS-1:0] w_occ;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        assign w_hit[g] = (cell_at(board, WIN_LINES[g][0]) == mark) &&
                          (cell_at(board, WIN_LINES[g][1]) == mark) &&
                          (cell_at(board, WIN_LINES[g][2]) == mark);
    end

    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        assign w_occ[g] = (board[2*g +: 2] != EMPTY);
    end

    // An EMPTY mark would match blank lines, so it never reports a win.
    assign win  = (mark != EMPTY) && (|w_hit);
    assign full = &w_occ;

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe sequencer: owns the board, cursor and turn order, arbitrates
// human and computer moves, and detects win/draw after every write.
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter int FIRST_PLAYER = 0,
    parameter int CPU_TIMEOUT  = 255
)(
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        move_pulse,
    input  logic        select_pulse,
    input  logic        cpu_valid,
    input  logic [3:0]  cpu_pos,
    output logic        cpu_start,
    output logic        cpu_ack,
    output logic        illegal,
    output logic [17:0] board,
    output logic [3:0]  cursor,
    output logic [1:0]  winner
);

    localparam state_t      RESET_STATE = (FIRST_PLAYER != 0) ? C_REQ : P_TURN;
    localparam logic [15:0] LAST_WAIT   = 16'(CPU_TIMEOUT - 1);

    state_t      r_state;
    logic [17:0] r_board;
    logic [3:0]  r_cursor;
    logic [1:0]  r_winner;
    logic [1:0]  r_last_mark;
    logic [15:0] r_cnt;
    logic        r_cpu_start;
    logic        r_cpu_ack;
    logic        r_illegal;

    state_t      w_state_nxt;
    logic [17:0] w_board_nxt;
    logic [3:0]  w_cursor_nxt;
    logic [1:0]  w_winner_nxt;
    logic [1:0]  w_mark_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_start_nxt;
    logic        w_ack_nxt;
    logic        w_illegal_nxt;

    logic        w_win;
    logic        w_full;
    logic        w_cpu_legal;
    logic [3:0]  w_low_empty;

    ttt_win_check u_win_check (
        .board (r_board),
        .mark  (r_last_mark),
        .win   (w_win),
        .full  (w_full)
    );

    assign w_cpu_legal = (cpu_pos <= 4'd8) && (cell_at(r_board, cpu_pos) == EMPTY);

    // Fallback target; descending scan leaves the lowest empty index.
    always_comb begin
        w_low_empty = 4'd0;
        for (int i = NUM_CELLS - 1; i >= 0; i--)
            if (r_board[2*i +: 2] == EMPTY) w_low_empty = 4'(i);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_board_nxt   = r_board;
        w_cursor_nxt  = r_cursor;
        w_winner_nxt  = r_winner;
        w_mark_nxt    = r_last_mark;
        w_cnt_nxt     = r_cnt;
        w_start_nxt   = 1'b0;
        w_ack_nxt     = 1'b0;
        w_illegal_nxt = 1'b0;

        case (r_state)
            P_TURN: begin
                if (select_pulse) begin
                    if (cell_at(r_board, r_cursor) == EMPTY) begin
                        w_board_nxt = cell_put(r_board, r_cursor, PLAYER);
                        w_mark_nxt  = PLAYER;
                        w_state_nxt = CHECK;
                    end else begin
                        w_illegal_nxt = 1'b1;
                    end
                end else if (move_pulse) begin
                    w_cursor_nxt = (r_cursor == 4'd8) ? 4'd0 : r_cursor + 4'd1;
                end
            end

            C_REQ: begin
                w_start_nxt = 1'b1;
                w_cnt_nxt   = 16'd0;
                w_state_nxt = C_WAIT;
            end

            C_WAIT: begin
                if (cpu_valid && w_cpu_legal) begin
                    w_board_nxt = cell_put(r_board, cpu_pos, CPU);
                    w_ack_nxt   = 1'b1;
                    w_mark_nxt  = CPU;
                    w_state_nxt = CHECK;
                end else begin
                    w_illegal_nxt = cpu_valid;
                    // Counter started at cpu_start, so LAST_WAIT lands the write
                    // exactly CPU_TIMEOUT edges after the start pulse.
                    if (r_cnt == LAST_WAIT) begin
                        w_board_nxt = cell_put(r_board, w_low_empty, CPU);
                        w_mark_nxt  = CPU;
                        w_state_nxt = CHECK;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
            end

            CHECK: begin
                if (w_win) begin
                    w_winner_nxt = (r_last_mark == PLAYER) ? P_WIN : C_WIN;
                    w_cursor_nxt = 4'b1111;
                    w_state_nxt  = DONE;
                end else if (w_full) begin
                    w_winner_nxt = DRAW;
                    w_cursor_nxt = 4'b1111;
                    w_state_nxt  = DONE;
                end else begin
                    w_state_nxt = (r_last_mark == PLAYER) ? C_REQ : P_TURN;
                end
            end

            DONE: begin
            end

            default: w_state_nxt = RESET_STATE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state     <= RESET_STATE;
            r_board     <= '0;
            r_cursor    <= 4'd0;
            r_winner    <= NONE;
            r_last_mark <= EMPTY;
            r_cnt       <= 16'd0;
            r_cpu_start <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_board     <= w_board_nxt;
            r_cursor    <= w_cursor_nxt;
            r_winner    <= w_winner_nxt;
            r_last_mark <= w_mark_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cpu_start <= w_start_nxt;
            r_cpu_ack   <= w_ack_nxt;
            r_illegal   <= w_illegal_nxt;
        end
    end

    assign cpu_start = r_cpu_start;
    assign cpu_ack   = r_cpu_ack;
    assign illegal   = r_illegal;
    assign board     = r_board;
    assign cursor    = r_cursor;
    assign winner    = r_winner;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Scenario bench for ttt_turn_controller: board-write/pulse events are predicted
// into a queue and matched by a negedge monitor; tasks check timing inline.
module tb_ttt_turn_controller;

    localparam int T = 10;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        move_pulse = 1'b0;
    logic        select_pulse = 1'b0;
    logic        cpu_valid = 1'b0;
    logic [3:0]  cpu_pos = 4'd0;
    logic        cpu_start, cpu_ack, illegal;
    logic [17:0] board;
    logic [3:0]  cursor;
    logic [1:0]  winner;

    typedef struct {
        logic [17:0] board;
        logic        ack;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [17:0] mon_prev = '0;
    logic [17:0] m_board = '0;
    int          m_cursor = 0;

    ttt_turn_controller #(.FIRST_PLAYER(0), .CPU_TIMEOUT(T)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .move_pulse   (move_pulse),
        .select_pulse (select_pulse),
        .cpu_valid    (cpu_valid),
        .cpu_pos      (cpu_pos),
        .cpu_start    (cpu_start),
        .cpu_ack      (cpu_ack),
        .illegal      (illegal),
        .board        (board),
        .cursor       (cursor),
        .winner       (winner)
    );

    initial forever #5 CLOCK_50 = ~CLOCK_50;

    // Any board change or pulse must match the oldest prediction.
    always @(negedge CLOCK_50) begin
        if (mon_en && ((board !== mon_prev) || cpu_ack !== 1'b0 || illegal !== 1'b0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event board=%h ack=%b illegal=%b, expected no event", board, cpu_ack, illegal);
            end else begin
                e = exp_q.pop_front();
                if (board !== e.board || cpu_ack !== e.ack || illegal !== e.ill) begin
                    errors++;
                    $display("FAIL event board=%h ack=%b illegal=%b, expected board=%h ack=%b illegal=%b",
                             board, cpu_ack, illegal, e.board, e.ack, e.ill);
                end
            end
        end
        mon_prev = board;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset = 1'b1;
        move_pulse = 1'b0; select_pulse = 1'b0; cpu_valid = 1'b0; cpu_pos = 4'd0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        m_board = '0;
        m_cursor = 0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge CLOCK_50);
            n++;
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d outstanding events, expected 0", tag, exp_q.size());
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (cpu_start !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (cpu_start !== 1'b1) begin
            errors++;
            $display("FAIL cpu_start_timeout got no pulse in %0d cycles, expected one", n);
        end
    endtask

    task automatic human_play(input int target);
        int n;
        n = (target + 9 - m_cursor) % 9;
        repeat (n) begin
            move_pulse = 1'b1; tick(); move_pulse = 1'b0;
        end
        m_cursor = target;
        checks++;
        if (cursor !== 4'(target)) begin
            errors++;
            $display("FAIL cursor_before_select got %0d expected %0d", cursor, target);
        end
        if (m_board[2*target +: 2] == 2'b00) begin
            m_board[2*target +: 2] = 2'b01;
            exp_q.push_back('{m_board, 1'b0, 1'b0});
        end else begin
            exp_q.push_back('{m_board, 1'b0, 1'b1});
        end
        select_pulse = 1'b1; tick(); select_pulse = 1'b0;
    endtask

    task automatic cpu_play(input int pos);
        logic ok;
        ok = 1'b0;
        if (pos < 9)
            if (m_board[2*pos +: 2] == 2'b00) ok = 1'b1;
        if (ok) begin
            m_board[2*pos +: 2] = 2'b10;
            exp_q.push_back('{m_board, 1'b1, 1'b0});
        end else begin
            exp_q.push_back('{m_board, 1'b0, 1'b1});
        end
        cpu_valid = 1'b1; cpu_pos = 4'(pos); tick(); cpu_valid = 1'b0;
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        checks++;
        if (board !== 18'd0 || cursor !== 4'd0 || winner !== 2'b00) begin
            errors++;
            $display("FAIL reset_state got board=%h cursor=%0d winner=%b expected 0/0/00", board, cursor, winner);
        end
        checks++;
        if (cpu_start !== 1'b0 || cpu_ack !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses got start=%b ack=%b illegal=%b expected 000", cpu_start, cpu_ack, illegal);
        end
        reset = 1'b0; m_board = '0; m_cursor = 0; exp_q.delete(); mon_en = 1'b1;
        repeat (3) tick();
        checks++;
        if (cpu_start !== 1'b0 || cursor !== 4'd0) begin
            errors++;
            $display("FAIL human_first got start=%b cursor=%0d expected 0/0", cpu_start, cursor);
        end
    endtask

    task automatic test_cursor();
        do_reset();
        repeat (3) begin move_pulse = 1'b1; tick(); move_pulse = 1'b0; end
        checks++;
        if (cursor !== 4'd3) begin
            errors++;
            $display("FAIL cursor_three got %0d expected 3", cursor);
        end
        repeat (9) begin move_pulse = 1'b1; tick(); move_pulse = 1'b0; tick(); end
        checks++;
        if (cursor !== 4'd3) begin
            errors++;
            $display("FAIL cursor_wrap got %0d expected 3", cursor);
        end
        drain("cursor");
    endtask

    task automatic test_win();
        int n;
        do_reset();
        human_play(0);
        wait_start(n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL start_latency got %0d cycles expected 2", n);
        end
        cpu_play(4);
        checks++;
        if (cpu_start !== 1'b0) begin
            errors++;
            $display("FAIL start_width got start=%b expected 0", cpu_start);
        end
        tick();
        human_play(1);
        wait_start(n);
        cpu_play(3);
        tick();
        human_play(2);
        checks++;
        if (winner !== 2'b00) begin
            errors++;
            $display("FAIL win_early got winner=%b expected 00", winner);
        end
        tick();
        checks++;
        if (winner !== 2'b01 || cursor !== 4'b1111) begin
            errors++;
            $display("FAIL human_win got winner=%b cursor=%b expected 01/1111", winner, cursor);
        end
        move_pulse = 1'b1; tick(); move_pulse = 1'b0;
        select_pulse = 1'b1; tick(); select_pulse = 1'b0;
        cpu_valid = 1'b1; cpu_pos = 4'd5; repeat (3) tick(); cpu_valid = 1'b0;
        checks++;
        if (winner !== 2'b01 || cursor !== 4'b1111 || cpu_start !== 1'b0) begin
            errors++;
            $display("FAIL done_frozen got winner=%b cursor=%b start=%b expected 01/1111/0", winner, cursor, cpu_start);
        end
        drain("win");
    endtask

    task automatic test_illegal();
        int n;
        do_reset();
        human_play(4);
        wait_start(n);
        cpu_play(4);
        cpu_play(9);
        cpu_play(8);
        tick();
        checks++;
        if (board[17:16] !== 2'b10) begin
            errors++;
            $display("FAIL cpu_cell8 got %b expected 10", board[17:16]);
        end
        human_play(4);
        move_pulse = 1'b1; tick(); move_pulse = 1'b0;
        m_cursor = 5;
        m_board[11:10] = 2'b01;
        exp_q.push_back('{m_board, 1'b0, 1'b0});
        move_pulse = 1'b1; select_pulse = 1'b1; tick(); move_pulse = 1'b0; select_pulse = 1'b0;
        checks++;
        if (cursor !== 4'd5) begin
            errors++;
            $display("FAIL select_beats_move got cursor=%0d expected 5", cursor);
        end
        drain("illegal");
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        human_play(0);
        wait_start(n);
        m_board[3:2] = 2'b10;
        exp_q.push_back('{m_board, 1'b0, 1'b0});
        repeat (T - 1) tick();
        checks++;
        if (board[3:2] !== 2'b00) begin
            errors++;
            $display("FAIL timeout_early got cell1=%b at cycle %0d expected 00", board[3:2], T - 1);
        end
        tick();
        checks++;
        if (board[3:2] !== 2'b10 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL timeout_move got cell1=%b ack=%b expected 10/0", board[3:2], cpu_ack);
        end
        tick();
        checks++;
        if (winner !== 2'b00 || cpu_start !== 1'b0) begin
            errors++;
            $display("FAIL timeout_handoff got winner=%b start=%b expected 00/0", winner, cpu_start);
        end
        drain("timeout");
    endtask

    task automatic test_draw();
        int n;
        do_reset();
        human_play(0); wait_start(n); cpu_play(4); tick();
        human_play(2); wait_start(n); cpu_play(1); tick();
        human_play(7); wait_start(n); cpu_play(6); tick();
        human_play(3); wait_start(n); cpu_play(5); tick();
        human_play(8);
        checks++;
        if (winner !== 2'b00) begin
            errors++;
            $display("FAIL draw_early got winner=%b expected 00", winner);
        end
        tick();
        checks++;
        if (winner !== 2'b11 || cursor !== 4'b1111) begin
            errors++;
            $display("FAIL draw got winner=%b cursor=%b expected 11/1111", winner, cursor);
        end
        drain("draw");
    endtask

    task automatic test_reset_midwait();
        int n;
        do_reset();
        human_play(0);
        wait_start(n);
        cpu_valid = 1'b1; cpu_pos = 4'd4;
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (board !== 18'd0 || cpu_ack !== 1'b0 || cursor !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got board=%h ack=%b cursor=%0d expected 0/0/0", board, cpu_ack, cursor);
        end
        tick();
        checks++;
        if (board !== 18'd0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got board=%h ack=%b expected 0/0", board, cpu_ack);
        end
        #2;
        reset = 1'b0; cpu_valid = 1'b0;
        m_board = '0; m_cursor = 0; exp_q.delete(); mon_en = 1'b1;
        tick();
        human_play(1);
        wait_start(n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL post_reset_p_turn got start after %0d cycles expected 2", n);
        end
        drain("midwait");
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_win();
        test_illegal();
        test_timeout();
        test_draw();
        test_reset_midwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
